// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode stage: combinational decode of the incoming word, then a
// two-entry output/skid buffer so in_ready_o comes straight from a flop.
module rv_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_inst_i,
    input  logic [XLEN-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [6:0]      op_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            uses_rs1_o,
    output logic            uses_rs2_o,
    output logic            writes_rd_o,
    output logic            illegal_o
);

    localparam logic [6:0] OP_R3    = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam bit IS_RV32 = (XLEN == 32);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      op;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
        logic            illegal;
    } dec_t;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [2:0]      fmt;
    logic            legal;
    logic            is_shift;
    logic [5:0]      shamt;
    logic [XLEN-1:0] imm_v;
    dec_t            dec;

    dec_t            or_q, or_d;
    dec_t            sk_q, sk_d;
    logic            or_valid_q, or_valid_d;
    logic            sk_valid_q, sk_valid_d;
    logic            in_fire;
    logic            out_fire;
    logic            or_free;

    assign opc   = in_inst_i[6:0];
    assign f3    = in_inst_i[14:12];
    assign f7    = in_inst_i[31:25];
    assign shamt = IS_RV32 ? {1'b0, in_inst_i[24:20]} : in_inst_i[25:20];

    // Opcode classification and legality; opcodes all end in 2'b11 so a
    // compressed-looking word falls into the default arm.
    always_comb begin
        fmt      = FMT_R;
        legal    = 1'b1;
        is_shift = 1'b0;
        case (opc)
            OP_R3: begin
                fmt   = FMT_R;
                legal = (f7 == 7'b0000000)
                      || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                      || (f7 == 7'b0000001 && ENABLE_M);
            end
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            OP_JALR: begin
                fmt   = FMT_I;
                legal = (f3 == 3'b000);
            end
            OP_BR: begin
                fmt   = FMT_B;
                legal = !(f3 == 3'b010 || f3 == 3'b011);
            end
            OP_LD: begin
                fmt   = FMT_I;
                legal = !(f3 == 3'b111 || (IS_RV32 && (f3 == 3'b011 || f3 == 3'b110)));
            end
            OP_ST: begin
                fmt   = FMT_S;
                legal = !(f3[2] || (IS_RV32 && f3 == 3'b011));
            end
            OP_IMM: begin
                fmt = FMT_I;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    is_shift = 1'b1;
                    legal    = ((f7[6:1] == 6'b000000)
                             || (f7[6:1] == 6'b010000 && f3 == 3'b101))
                             && !(IS_RV32 && f7[0]);
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        imm_v = '0;
        case (fmt)
            FMT_I: begin
                if (is_shift) begin
                    imm_v = {{(XLEN-6){1'b0}}, shamt};
                end else begin
                    imm_v = {{(XLEN-12){in_inst_i[31]}}, in_inst_i[31:20]};
                end
            end
            FMT_S: imm_v = {{(XLEN-12){in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
            FMT_B: imm_v = {{(XLEN-12){in_inst_i[31]}}, in_inst_i[7], in_inst_i[30:25],
                            in_inst_i[11:8], 1'b0};
            // Upper bits beyond bit 31 are copies of inst[31] on RV64.
            FMT_U: imm_v = {{(XLEN-31){in_inst_i[31]}}, in_inst_i[30:12], 12'b0};
            FMT_J: imm_v = {{(XLEN-20){in_inst_i[31]}}, in_inst_i[19:12], in_inst_i[20],
                            in_inst_i[30:21], 1'b0};
            default: imm_v = '0;
        endcase
    end

    always_comb begin
        dec    = '0;
        dec.pc = in_pc_i;
        if (!legal) begin
            dec.illegal = 1'b1;
        end else begin
            dec.op  = opc;
            dec.fmt = fmt;
            dec.imm = imm_v;
            if (fmt != FMT_U && fmt != FMT_J) begin
                dec.rs1      = in_inst_i[19:15];
                dec.funct3   = f3;
                dec.uses_rs1 = 1'b1;
            end
            if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) begin
                dec.rs2      = in_inst_i[24:20];
                dec.uses_rs2 = 1'b1;
            end
            if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) begin
                dec.rd        = in_inst_i[11:7];
                dec.writes_rd = |in_inst_i[11:7];
            end
            if (fmt == FMT_R || is_shift) begin
                dec.funct7 = f7;
            end
        end
    end

    assign in_ready_o = !sk_valid_q;
    assign in_fire    = in_valid_i && !sk_valid_q;
    assign out_fire   = or_valid_q && out_ready_i;
    assign or_free    = !or_valid_q || out_fire;

    // Skid contents always take precedence over a new word so order is kept;
    // a new word can only arrive while the skid slot is empty.
    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        if (flush_i) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else if (sk_valid_q && or_free) begin
            or_d       = sk_q;
            or_valid_d = 1'b1;
            sk_valid_d = 1'b0;
        end else if (in_fire && or_free) begin
            or_d       = dec;
            or_valid_d = 1'b1;
        end else if (in_fire) begin
            sk_d       = dec;
            sk_valid_d = 1'b1;
        end else if (out_fire) begin
            or_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
        end
    end

    assign out_valid_o = or_valid_q;
    assign out_pc_o    = or_q.pc;
    assign rs1_o       = or_q.rs1;
    assign rs2_o       = or_q.rs2;
    assign rd_o        = or_q.rd;
    assign op_o        = or_q.op;
    assign funct3_o    = or_q.funct3;
    assign funct7_o    = or_q.funct7;
    assign imm_o       = or_q.imm;
    assign fmt_o       = or_q.fmt;
    assign uses_rs1_o  = or_q.uses_rs1;
    assign uses_rs2_o  = or_q.uses_rs2;
    assign writes_rd_o = or_q.writes_rd;
    assign illegal_o   = or_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: an RV32 (no M) and an RV64 (with M) instance share
// stimulus; a queue-based reference model predicts every output.
module tb_rv_decode_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        u1;
        logic        u2;
        logic        wr;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [63:0] pc;

    logic        a_in_ready, a_out_valid, a_u1, a_u2, a_wr, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [6:0]  a_op, a_f7;
    logic [2:0]  a_f3, a_fmt;

    logic        b_in_ready, b_out_valid, b_u1, b_u2, b_wr, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [6:0]  b_op, b_f7;
    logic [2:0]  b_f3, b_fmt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .in_inst_i(inst), .in_pc_i(pc[31:0]),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .out_pc_o(a_pc), .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
        .op_o(a_op), .funct3_o(a_f3), .funct7_o(a_f7), .imm_o(a_imm),
        .fmt_o(a_fmt), .uses_rs1_o(a_u1), .uses_rs2_o(a_u2),
        .writes_rd_o(a_wr), .illegal_o(a_ill)
    );

    rv_decode_stage #(.XLEN(64), .ENABLE_M(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready),
        .in_inst_i(inst), .in_pc_i(pc),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready),
        .out_pc_o(b_pc), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
        .op_o(b_op), .funct3_o(b_f3), .funct7_o(b_f7), .imm_o(b_imm),
        .fmt_o(b_fmt), .uses_rs1_o(b_u1), .uses_rs2_o(b_u2),
        .writes_rd_o(b_wr), .illegal_o(b_ill)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, want);
        end
    endtask

    function automatic longint sx(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        if (v >= half) return v - (half << 1);
        return v;
    endfunction

    // Reference decode built from the ISA field rules with plain arithmetic.
    function automatic exp_t model(input logic [31:0] i, input int xlen, input bit em,
                                   input logic [63:0] pcv);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          fm;
        bit          ok;
        bit          sh;
        longint      v;
        logic [63:0] mask;
        e    = '0;
        f3   = i[14:12];
        f7   = i[31:25];
        fm   = 0;
        ok   = 1'b1;
        sh   = 1'b0;
        v    = 0;
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        e.pc = pcv & mask;
        case (i[6:0])
            7'h33: begin
                fm = 0;
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
                   || (f7 == 7'h01 && em);
            end
            7'h37, 7'h17: fm = 4;
            7'h6F:        fm = 5;
            7'h67: begin fm = 1; ok = (f3 == 3'd0); end
            7'h63: begin fm = 3; ok = !(f3 == 3'd2 || f3 == 3'd3); end
            7'h03: begin fm = 1; ok = !(f3 == 3'd7 || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6))); end
            7'h23: begin fm = 2; ok = (f3 < 3'd4) && !(xlen == 32 && f3 == 3'd3); end
            7'h13: begin
                fm = 1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    sh = 1'b1;
                    ok = (f7[6:1] == 6'd0) || (f7[6:1] == 6'b010000 && f3 == 3'd5);
                    if (xlen == 32 && f7[0]) ok = 1'b0;
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.ill = 1'b1;
            return e;
        end
        e.op  = i[6:0];
        e.fmt = 3'(fm);
        if (fm <= 3) begin e.rs1 = i[19:15]; e.f3 = f3; e.u1 = 1'b1; end
        if (fm == 0 || fm == 2 || fm == 3) begin e.rs2 = i[24:20]; e.u2 = 1'b1; end
        if (fm == 0 || fm == 1 || fm >= 4) begin e.rd = i[11:7]; e.wr = (i[11:7] != 5'd0); end
        if (fm == 0 || sh) e.f7 = f7;
        case (fm)
            1: v = sh ? ((xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]))
                      : sx(longint'(i[31:20]), 12);
            2: v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            3: v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                      + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            4: v = sx(longint'(i[31:12]), 20) * 4096;
            5: v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                      + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            default: v = 0;
        endcase
        e.imm = 64'(v) & mask;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [9];
        int          k;
        ops = '{7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13};
        r   = $urandom;
        k   = int'($urandom_range(0, 11));
        if (k < 9) r[6:0] = ops[k];
        else if (k == 9) r[1:0] = 2'($urandom_range(0, 2));
        case ($urandom_range(0, 4))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            3: r[31:26] = 6'h00;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_a(input string tag, input exp_t e);
        chk({tag, ".a.pc"},   64'(a_pc),  e.pc);
        chk({tag, ".a.rs1"},  64'(a_rs1), 64'(e.rs1));
        chk({tag, ".a.rs2"},  64'(a_rs2), 64'(e.rs2));
        chk({tag, ".a.rd"},   64'(a_rd),  64'(e.rd));
        chk({tag, ".a.op"},   64'(a_op),  64'(e.op));
        chk({tag, ".a.f3"},   64'(a_f3),  64'(e.f3));
        chk({tag, ".a.f7"},   64'(a_f7),  64'(e.f7));
        chk({tag, ".a.imm"},  64'(a_imm), e.imm);
        chk({tag, ".a.fmt"},  64'(a_fmt), 64'(e.fmt));
        chk({tag, ".a.flags"}, 64'({a_u1, a_u2, a_wr, a_ill}), 64'({e.u1, e.u2, e.wr, e.ill}));
    endtask

    task automatic check_b(input string tag, input exp_t e);
        chk({tag, ".b.pc"},   b_pc,        e.pc);
        chk({tag, ".b.rs1"},  64'(b_rs1), 64'(e.rs1));
        chk({tag, ".b.rs2"},  64'(b_rs2), 64'(e.rs2));
        chk({tag, ".b.rd"},   64'(b_rd),  64'(e.rd));
        chk({tag, ".b.op"},   64'(b_op),  64'(e.op));
        chk({tag, ".b.f3"},   64'(b_f3),  64'(e.f3));
        chk({tag, ".b.f7"},   64'(b_f7),  64'(e.f7));
        chk({tag, ".b.imm"},  b_imm,       e.imm);
        chk({tag, ".b.fmt"},  64'(b_fmt), 64'(e.fmt));
        chk({tag, ".b.flags"}, 64'({b_u1, b_u2, b_wr, b_ill}), 64'({e.u1, e.u2, e.wr, e.ill}));
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a.out_valid"}, 64'(a_out_valid), 64'(qa.size() > 0));
        chk({tag, ".a.in_ready"},  64'(a_in_ready),  64'(qa.size() < 2));
        chk({tag, ".b.out_valid"}, 64'(b_out_valid), 64'(qb.size() > 0));
        chk({tag, ".b.in_ready"},  64'(b_in_ready),  64'(qb.size() < 2));
        if (qa.size() > 0) check_a(tag, qa[0]);
        if (qb.size() > 0) check_b(tag, qb[0]);
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z = '0;
        chk({tag, ".a.out_valid"}, 64'(a_out_valid), 64'd0);
        chk({tag, ".a.in_ready"},  64'(a_in_ready),  64'd1);
        chk({tag, ".b.out_valid"}, 64'(b_out_valid), 64'd0);
        chk({tag, ".b.in_ready"},  64'(b_in_ready),  64'd1);
        check_a(tag, z);
        check_b(tag, z);
    endtask

    // One cycle: drive at the falling edge, update the model, check at the next falling edge.
    task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl,
                        input string tag);
        bit can_in;
        bit has_out;
        can_in    = (qa.size() < 2);
        has_out   = (qa.size() > 0);
        in_valid  = v;
        inst      = ins;
        pc        = {$urandom, $urandom};
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (has_out && ordy) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (v && can_in) begin
                qa.push_back(model(ins, 32, 1'b0, pc));
                qb.push_back(model(ins, 64, 1'b1, pc));
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_all(tag);
    endtask

    task automatic stream_test();
        logic [31:0] prog [6];
        int          idx;
        int          popped;
        bit          ordy;
        bit          rdy_now;
        for (int j = 0; j < 6; j++) prog[j] = rand_inst();
        idx    = 0;
        popped = 0;
        for (int c = 0; c < 40 && popped < 6; c++) begin
            ordy    = (c >= 3);
            rdy_now = (qa.size() < 2);
            if (a_out_valid && ordy) popped++;
            step(idx < 6, prog[(idx < 6) ? idx : 0], ordy, 1'b0, "stream");
            if (idx < 6 && rdy_now) idx++;
            if (c == 1) chk("stream.in_ready_after_2", 64'(a_in_ready), 64'd0);
        end
        chk("stream.accepted", 64'(idx), 64'd6);
        chk("stream.emerged", 64'(popped), 64'd6);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inst      = 32'h0;
        pc        = 64'h0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        check_all("post_reset");

        step(1'b1, 32'hFFF0_0093, 1'b1, 1'b0, "addi");
        chk("addi.a.imm", 64'(a_imm), 64'h0000_0000_FFFF_FFFF);
        chk("addi.a.rd", 64'(a_rd), 64'd1);
        chk("addi.a.rs1", 64'(a_rs1), 64'd0);
        chk("addi.a.fmt", 64'(a_fmt), 64'd1);
        chk("addi.a.uses_rs2", 64'(a_u2), 64'd0);
        chk("addi.a.writes_rd", 64'(a_wr), 64'd1);
        chk("addi.b.imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        step(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0, "beq");
        chk("beq.a.imm", 64'(a_imm), 64'h0000_0000_FFFF_FFFC);
        chk("beq.a.fmt", 64'(a_fmt), 64'd3);
        chk("beq.a.rd", 64'(a_rd), 64'd0);
        chk("beq.a.writes_rd", 64'(a_wr), 64'd0);

        step(1'b1, 32'h0010_00EF, 1'b1, 1'b0, "jal");
        chk("jal.a.imm", 64'(a_imm), 64'h800);
        chk("jal.a.fmt", 64'(a_fmt), 64'd5);

        step(1'b1, 32'h1234_52B7, 1'b1, 1'b0, "lui");
        chk("lui.a.imm", 64'(a_imm), 64'h1234_5000);
        chk("lui.a.rd", 64'(a_rd), 64'd5);

        step(1'b1, 32'h4051_D193, 1'b1, 1'b0, "srai");
        chk("srai.a.imm", 64'(a_imm), 64'd5);
        chk("srai.a.funct7", 64'(a_f7), 64'h20);
        chk("srai.a.illegal", 64'(a_ill), 64'd0);

        step(1'b1, 32'h0231_00B3, 1'b1, 1'b0, "mul");
        chk("mul.a.illegal", 64'(a_ill), 64'd1);
        chk("mul.b.illegal", 64'(b_ill), 64'd0);
        chk("mul.a.rd_zeroed", 64'(a_rd), 64'd0);

        step(1'b1, 32'h0261_D193, 1'b1, 1'b0, "shamt5");
        chk("shamt5.a.illegal", 64'(a_ill), 64'd1);
        chk("shamt5.b.imm", b_imm, 64'd38);

        step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
        stream_test();

        step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
        step(1'b1, rand_inst(), 1'b0, 1'b0, "fill");
        step(1'b1, rand_inst(), 1'b0, 1'b0, "fill");
        chk("fill.in_ready", 64'(a_in_ready), 64'd0);
        step(1'b1, rand_inst(), 1'b1, 1'b1, "flush_full");
        chk("flush_full.out_valid", 64'(a_out_valid), 64'd0);
        chk("flush_full.in_ready", 64'(a_in_ready), 64'd1);
        step(1'b1, rand_inst(), 1'b0, 1'b0, "refill");
        step(1'b1, rand_inst(), 1'b1, 1'b1, "flush_hs");
        chk("flush_hs.out_valid", 64'(b_out_valid), 64'd0);
        step(1'b1, rand_inst(), 1'b1, 1'b0, "after_flush");
        step(1'b0, 32'h0, 1'b1, 1'b0, "drain");

        step(1'b1, rand_inst(), 1'b0, 1'b0, "prerst");
        step(1'b1, rand_inst(), 1'b0, 1'b0, "prerst");
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        qa.delete();
        qb.delete();
        #1 rst = 1'b0;
        step(1'b1, 32'hFFF0_0093, 1'b1, 1'b0, "rst_first");
        chk("rst_first.a.out_valid", 64'(a_out_valid), 64'd1);
        chk("rst_first.a.imm", 64'(a_imm), 64'h0000_0000_FFFF_FFFF);

        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
